// File: rtl/bounce_sprite_gen.sv
// Pixel stage: one square sprite bouncing in the 640x480 active area.
// Define SPRITE_BORDER_EN to draw a white 2-pixel ring around the sprite.
module bounce_sprite_gen #(
    parameter int unsigned SIZE         = 16,
    parameter int unsigned SPEED        = 2,
    parameter int unsigned X0           = 0,
    parameter int unsigned Y0           = 0,
    parameter int unsigned FLASH_FRAMES = 8,
    parameter logic [11:0] BG_RGB       = 12'h004,
    parameter logic [11:0] FG_RGB       = 12'hFF0,
    parameter logic [11:0] FL_RGB       = 12'hF00
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [9:0]  pix_x,
    input  logic [9:0]  pix_y,
    input  logic        video_on,
    input  logic        ref_tick,
    input  logic        h_sync_in,
    input  logic        v_sync_in,
    input  logic        pause_tgl,
    output logic [11:0] rgb,
    output logic        h_sync_out,
    output logic        v_sync_out,
    output logic        bounce
);

    localparam logic [10:0] SZ    = 11'(SIZE);
    localparam logic [10:0] SP    = 11'(SPEED);
    localparam logic [10:0] X_LIM = 11'd640;
    localparam logic [10:0] Y_LIM = 11'd480;

    typedef enum logic [1:0] {
        RUN,
        FLASH,
        PAUSED
    } state_t;

    typedef struct packed {
        logic [9:0] s;
        logic       d;
        logic       hit;
    } axis_t;

    state_t     state;
    logic [7:0] fcnt;
    logic [9:0] sx;
    logic [9:0] sy;
    logic       dx;
    logic       dy;

    axis_t      nx;
    axis_t      ny;

    // One axis of the per-frame move; walls clamp the sprite and reverse it.
    function automatic axis_t step_axis(
        input logic [9:0]  s,
        input logic        d,
        input logic [10:0] lim
    );
        axis_t      r;
        logic [10:0] s11;
        s11   = {1'b0, s};
        r.s   = s;
        r.d   = d;
        r.hit = 1'b0;
        if (d) begin
            if (s11 + SZ + SP > lim) begin
                r.s   = 10'(lim - SZ);
                r.d   = 1'b0;
                r.hit = 1'b1;
            end else begin
                r.s = 10'(s11 + SP);
            end
        end else begin
            if (s11 < SP) begin
                r.s   = '0;
                r.d   = 1'b1;
                r.hit = 1'b1;
            end else begin
                r.s = 10'(s11 - SP);
            end
        end
        return r;
    endfunction

    assign nx = step_axis(sx, dx, X_LIM);
    assign ny = step_axis(sy, dy, Y_LIM);

    logic [10:0] ax;
    logic [10:0] ay;
    logic [10:0] sx11;
    logic [10:0] sy11;
    logic        in_x;
    logic        in_y;
    logic        spr_hit;
    logic [11:0] pix_rgb;

    assign ax      = {1'b0, pix_x} - 11'd144;
    assign ay      = {1'b0, pix_y} - 11'd35;
    assign sx11    = {1'b0, sx};
    assign sy11    = {1'b0, sy};
    assign in_x    = (ax >= sx11) && (ax < sx11 + SZ);
    assign in_y    = (ay >= sy11) && (ay < sy11 + SZ);
    assign spr_hit = in_x && in_y;

`ifdef SPRITE_BORDER_EN
    logic on_ring;
    assign on_ring = (ax - sx11 < 11'd2) ||
                     (sx11 + SZ - 11'd1 - ax < 11'd2) ||
                     (ay - sy11 < 11'd2) ||
                     (sy11 + SZ - 11'd1 - ay < 11'd2);
`endif

    always_comb begin
        pix_rgb = '0;
        if (video_on) begin
            if (spr_hit) begin
                pix_rgb = (state == FLASH) ? FL_RGB : FG_RGB;
`ifdef SPRITE_BORDER_EN
                if (on_ring) begin
                    pix_rgb = 12'hFFF;
                end
`endif
            end else begin
                pix_rgb = BG_RGB;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rgb        <= '0;
            h_sync_out <= 1'b0;
            v_sync_out <= 1'b0;
        end else begin
            rgb        <= pix_rgb;
            h_sync_out <= h_sync_in;
            v_sync_out <= v_sync_in;
        end
    end

    // Pause toggle outranks the frame tick, so a coincident tick never moves.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state  <= RUN;
            fcnt   <= '0;
            sx     <= 10'(X0);
            sy     <= 10'(Y0);
            dx     <= 1'b1;
            dy     <= 1'b1;
            bounce <= 1'b0;
        end else begin
            bounce <= 1'b0;
            if (pause_tgl) begin
                if (state == PAUSED) begin
                    state <= RUN;
                end else begin
                    state <= PAUSED;
                    fcnt  <= '0;
                end
            end else if (ref_tick && state != PAUSED) begin
                sx <= nx.s;
                dx <= nx.d;
                sy <= ny.s;
                dy <= ny.d;
                if (nx.hit || ny.hit) begin
                    bounce <= 1'b1;
                    state  <= FLASH;
                    fcnt   <= 8'(FLASH_FRAMES);
                end else if (state == FLASH) begin
                    fcnt <= fcnt - 8'd1;
                    if (fcnt == 8'd1) begin
                        state <= RUN;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_bounce_sprite_gen.sv
// Bench for bounce_sprite_gen: vector table, directed corners, random vs model.
module tb_bounce_sprite_gen;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [9:0]  pix_x = '0;
    logic [9:0]  pix_y = '0;
    logic        video_on = 1'b0;
    logic        ref_tick = 1'b0;
    logic        h_sync_in = 1'b0;
    logic        v_sync_in = 1'b0;
    logic        pause_tgl = 1'b0;
    logic [11:0] rgb;
    logic        h_sync_out;
    logic        v_sync_out;
    logic        bounce;
    logic [11:0] rgb2;
    logic        h_sync_out2;
    logic        v_sync_out2;
    logic        bounce2;

    bounce_sprite_gen dut (
        .clk(clk), .rst(rst), .pix_x(pix_x), .pix_y(pix_y),
        .video_on(video_on), .ref_tick(ref_tick),
        .h_sync_in(h_sync_in), .v_sync_in(v_sync_in),
        .pause_tgl(pause_tgl), .rgb(rgb), .h_sync_out(h_sync_out),
        .v_sync_out(v_sync_out), .bounce(bounce)
    );

    bounce_sprite_gen #(.X0(624), .Y0(464)) dut2 (
        .clk(clk), .rst(rst), .pix_x(pix_x), .pix_y(pix_y),
        .video_on(video_on), .ref_tick(ref_tick),
        .h_sync_in(h_sync_in), .v_sync_in(v_sync_in),
        .pause_tgl(pause_tgl), .rgb(rgb2), .h_sync_out(h_sync_out2),
        .v_sync_out(v_sync_out2), .bounce(bounce2)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Reference model: sprite position/direction as plain integers.
    int mx, my, mdx, mdy, mode, mcnt;
    logic [11:0] prev_rgb;
    logic        prev_hs;
    logic        prev_vs;

    typedef struct {
        int          px;
        int          py;
        logic [11:0] want;
    } vec_t;
    vec_t tbl[9];

    task automatic chk(input string nm, input logic [11:0] act, input logic [11:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    task automatic chk1(input string nm, input logic act, input logic exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %b want %b", nm, act, exp);
        end
    endtask

    task automatic model_reset();
        mx = 0; my = 0; mdx = 1; mdy = 1; mode = 0; mcnt = 0;
        prev_rgb = '0; prev_hs = 1'b0; prev_vs = 1'b0;
    endtask

    function automatic logic [11:0] exp_rgb(input int px, input int py, input bit von);
        int ax, ay;
        if (!von) return 12'h000;
        ax = px - 144;
        ay = py - 35;
        if (ax >= mx && ax < mx + 16 && ay >= my && ay < my + 16) begin
`ifdef SPRITE_BORDER_EN
            if (ax - mx < 2 || mx + 15 - ax < 2 || ay - my < 2 || my + 15 - ay < 2)
                return 12'hFFF;
`endif
            return (mode == 1) ? 12'hF00 : 12'hFF0;
        end
        return 12'h004;
    endfunction

    task automatic move(inout int p, inout int d, input int lim, output bit hit);
        int n;
        hit = 1'b0;
        n = (d != 0) ? p + 2 : p - 2;
        if (n + 16 > lim) begin
            p = lim - 16; d = 0; hit = 1'b1;
        end else if (n < 0) begin
            p = 0; d = 1; hit = 1'b1;
        end else begin
            p = n;
        end
    endtask

    task automatic model_step(input bit tk, input bit tg, output bit hit);
        bit hx, hy;
        hit = 1'b0;
        if (tg) begin
            if (mode == 2) mode = 0;
            else begin mode = 2; mcnt = 0; end
        end else if (tk && mode != 2) begin
            move(mx, mdx, 640, hx);
            move(my, mdy, 480, hy);
            hit = hx | hy;
            if (hit) begin
                mode = 1; mcnt = 8;
            end else if (mode == 1) begin
                mcnt--;
                if (mcnt == 0) mode = 0;
            end
        end
    endtask

    // Drive one pixel cycle; starts and ends 1 time unit after a rising edge.
    task automatic cyc_core(input int px, input int py, input bit tk, input bit tg,
                            input bit use_want, input logic [11:0] want);
        bit von, hs, vs, h;
        logic [11:0] er;
        von = (px >= 144 && px < 784 && py >= 35 && py < 515);
        hs  = 1'($urandom_range(0, 1));
        vs  = 1'($urandom_range(0, 1));
        pix_x = 10'(px); pix_y = 10'(py); video_on = von;
        ref_tick = tk; pause_tgl = tg; h_sync_in = hs; v_sync_in = vs;
        er = use_want ? want : exp_rgb(px, py, von);
        model_step(tk, tg, h);
        #1;
        chk("rgb_hold", rgb, prev_rgb);
        chk1("hsync_hold", h_sync_out, prev_hs);
        @(posedge clk);
        #1;
        chk("rgb", rgb, er);
        chk1("bounce", bounce, h);
        chk1("hsync", h_sync_out, hs);
        chk1("vsync", v_sync_out, vs);
        prev_rgb = er; prev_hs = hs; prev_vs = vs;
        ref_tick = 1'b0; pause_tgl = 1'b0;
    endtask

    task automatic cyc(input int px, input int py, input bit tk, input bit tg);
        cyc_core(px, py, tk, tg, 1'b0, 12'h000);
    endtask

    task automatic cycw(input int px, input int py, input logic [11:0] want);
        cyc_core(px, py, 1'b0, 1'b0, 1'b1, want);
    endtask

    initial begin
        logic [11:0] corner;
`ifdef SPRITE_BORDER_EN
        corner = 12'hFFF;
`else
        corner = 12'hFF0;
`endif
        tbl[0] = '{144, 35, corner};
        tbl[1] = '{159, 50, corner};
        tbl[2] = '{159, 35, corner};
        tbl[3] = '{146, 37, 12'hFF0};
        tbl[4] = '{160, 35, 12'h004};
        tbl[5] = '{144, 51, 12'h004};
        tbl[6] = '{100, 35, 12'h000};
        tbl[7] = '{144, 520, 12'h000};
        tbl[8] = '{783, 514, 12'h004};

        model_reset();
        rst = 1'b0;
        h_sync_in = 1'b1; v_sync_in = 1'b1;
        pix_x = 10'd150; pix_y = 10'd40; video_on = 1'b1; ref_tick = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_rgb", rgb, 12'h000);
        chk1("reset_hsync", h_sync_out, 1'b0);
        chk1("reset_vsync", v_sync_out, 1'b0);
        chk1("reset_bounce", bounce, 1'b0);
        chk("reset_rgb2", rgb2, 12'h000);
        ref_tick = 1'b0;
        rst = 1'b1;

        for (int i = 0; i < 9; i++) cycw(tbl[i].px, tbl[i].py, tbl[i].want);

        // Three frames from reset: sprite at (6,6), no wall contact.
        for (int i = 0; i < 3; i++) cyc(0, 0, 1'b1, 1'b0);
        cycw(152, 43, 12'hFF0);
        cycw(149, 43, 12'h004);

        // Pause coincident with tick, two frozen ticks, then resume.
        cyc(0, 0, 1'b1, 1'b1);
        cyc(0, 0, 1'b1, 1'b0);
        cyc(0, 0, 1'b1, 1'b0);
        cycw(152, 43, 12'hFF0);
        cycw(149, 43, 12'h004);
        cyc(0, 0, 1'b0, 1'b1);
        cyc(0, 0, 1'b1, 1'b0);
        cycw(154, 45, 12'hFF0);
        cycw(151, 45, 12'h004);

        for (int i = 0; i < 3000; i++) begin
            int px, py;
            bit tk, tg;
            if ($urandom_range(0, 1) == 1) begin
                px = 144 + mx + $urandom_range(0, 19) - 2;
                py = 35 + my + $urandom_range(0, 19) - 2;
            end else begin
                px = $urandom_range(0, 799);
                py = $urandom_range(0, 524);
            end
            tk = ($urandom_range(0, 2) == 0);
            tg = ($urandom_range(0, 49) == 0);
            cyc(px, py, tk, tg);
        end

        // Asynchronous reset in the middle of a visible sprite pixel.
        if (mode == 2) cyc(0, 0, 1'b0, 1'b1);
        cyc(144 + mx + 4, 35 + my + 4, 1'b0, 1'b0);
        rst = 1'b0;
        #1;
        chk("midreset_rgb", rgb, 12'h000);
        chk1("midreset_bounce", bounce, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        model_reset();
        rst = 1'b1;

        // Second instance starts in the bottom-right corner.
        for (int k = 1; k <= 10; k++) begin
            int sx2, sy2;
            cyc(0, 0, 1'b1, 1'b0);
            chk1("corner_bounce", bounce2, (k == 1));
            sx2 = 624 - 2 * (k - 1);
            sy2 = 464 - 2 * (k - 1);
            cyc(144 + sx2 + 4, 35 + sy2 + 4, 1'b0, 1'b0);
            chk("flash_rgb", rgb2, (k <= 8) ? 12'hF00 : 12'hFF0);
            chk1("corner_bounce_low", bounce2, 1'b0);
            if (k == 1) begin
                cyc(767, 499, 1'b0, 1'b0);
                chk("corner_left_bg", rgb2, 12'h004);
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
